// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial pattern detector: matches the last cfg_len accepted bits
// against a loaded pattern, pulses dout for one cycle per match, and counts matches.
module seq_detect_prog #(
    parameter int MAX_LEN       = 8,
    parameter int LEN_W         = $clog2(MAX_LEN) + 1,
    parameter int CNT_W         = 8,
    parameter int RESET_PATTERN = 'b1010,
    parameter int RESET_LEN     = 4,
    parameter bit RESET_OVERLAP = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               din_valid,
    input  logic               din,
    input  logic               cnt_clr,
    output logic               dout,
    output logic [CNT_W-1:0]   match_count,
    output logic               cnt_sat
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        logic [LEN_W-1:0] r;
        if (l == '0)
            r = LEN_ONE;
        else if (l > LEN_MAX)
            r = LEN_MAX;
        else
            r = l;
        return r;
    endfunction

    logic [MAX_LEN-1:0] pat_q, hist_q, hist_d, hist_shift, mask;
    logic [LEN_W-1:0]   len_q, fill_q, fill_d, fill_inc;
    logic               ovl_q, dout_q, accept, hit;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // din_valid qualifies din and there is no ready: every valid bit is consumed,
    // except in a cfg_load cycle, where the bit is dropped and detection restarts.
    always_comb begin
        accept     = din_valid && !cfg_load;
        hist_shift = {hist_q[MAX_LEN-2:0], din};
        fill_inc   = (fill_q >= len_q) ? fill_q : fill_q + LEN_ONE;
        mask       = '0;
        for (int i = 0; i < MAX_LEN; i++)
            mask[i] = (LEN_W'(i) < len_q);
        hit = accept && (fill_inc >= len_q) && (((hist_shift ^ pat_q) & mask) == '0);

        hist_d = hist_q;
        fill_d = fill_q;
        if (cfg_load) begin
            hist_d = '0;
            fill_d = '0;
        end else if (accept) begin
            if (hit && !ovl_q) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = hist_shift;
                fill_d = fill_inc;
            end
        end

        // Clear is applied before the increment so clear+match yields 1.
        cnt_d = cnt_clr ? '0 : cnt_q;
        if (hit && cnt_d != CNT_MAX)
            cnt_d = cnt_d + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q  <= MAX_LEN'(RESET_PATTERN);
            len_q  <= clamp_len(LEN_W'(RESET_LEN));
            ovl_q  <= RESET_OVERLAP;
            hist_q <= '0;
            fill_q <= '0;
            dout_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (cfg_load) begin
                pat_q <= cfg_pattern;
                len_q <= clamp_len(cfg_len);
                ovl_q <= cfg_overlap;
            end
            hist_q <= hist_d;
            fill_q <= fill_d;
            dout_q <= hit;
            cnt_q  <= cnt_d;
        end
    end

    assign dout        = dout_q;
    assign match_count = cnt_q;
    assign cnt_sat     = &cnt_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Bench for seq_detect_prog: directed scenarios plus a randomized run against a
// queue-based reference model; two instances share inputs (8-bit and 3-bit counters).
module tb_seq_detect_prog;

    logic       clk;
    logic       reset, cfg_load, cfg_overlap, din_valid, din, cnt_clr;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       dout8, cnt_sat8, dout3, cnt_sat3;
    logic [7:0] match_count8;
    logic [2:0] match_count3;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit         m_hist[$];
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ovl;
    bit         m_dout;
    int         m_cnt8, m_cnt3;

    seq_detect_prog #(.CNT_W(8)) dut8 (
        .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .din_valid(din_valid), .din(din),
        .cnt_clr(cnt_clr), .dout(dout8), .match_count(match_count8), .cnt_sat(cnt_sat8)
    );

    seq_detect_prog #(.CNT_W(3)) dut3 (
        .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .din_valid(din_valid), .din(din),
        .cnt_clr(cnt_clr), .dout(dout3), .match_count(match_count3), .cnt_sat(cnt_sat3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: a list of accepted bits since restart; a match is the newest
    // m_len bits equalling the pattern read from bit m_len-1 down to bit 0.
    task automatic model_step();
        bit hit;
        int n;
        hit = 0;
        if (reset) begin
            m_pat = 8'b1010; m_len = 4; m_ovl = 1;
            m_hist.delete();
            m_dout = 0; m_cnt8 = 0; m_cnt3 = 0;
            return;
        end
        if (cfg_load) begin
            m_pat = cfg_pattern;
            m_len = (cfg_len == 0) ? 1 : ((cfg_len > 8) ? 8 : int'(cfg_len));
            m_ovl = cfg_overlap;
            m_hist.delete();
        end else if (din_valid) begin
            m_hist.push_back(din);
            if (m_hist.size() > 8) void'(m_hist.pop_front());
            n = m_hist.size();
            if (n >= m_len) begin
                hit = 1;
                for (int k = 0; k < m_len; k++)
                    if (m_hist[n-1-k] != m_pat[k]) hit = 0;
            end
            if (hit && !m_ovl) m_hist.delete();
        end
        if (cnt_clr) begin m_cnt8 = 0; m_cnt3 = 0; end
        if (hit) begin
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt3 < 7) m_cnt3++;
        end
        m_dout = hit;
    endtask

    task automatic cycle(input bit rst, input bit ld, input bit v, input bit d, input bit clr);
        reset = rst; cfg_load = ld; din_valid = v; din = d; cnt_clr = clr;
        model_step();
        @(posedge clk);
        #1;
        reset = 0; cfg_load = 0; din_valid = 0; cnt_clr = 0;
    endtask

    task automatic load_cfg(input logic [7:0] p, input logic [3:0] l, input bit ovl);
        cfg_pattern = p; cfg_len = l; cfg_overlap = ovl;
        cycle(0, 1, 1, 1, 1);
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 1, 1, 0);
        n_cmp++;
        if (dout8 !== 1'b0 || match_count8 !== 8'd0 || cnt_sat8 !== 1'b0 ||
            dout3 !== 1'b0 || match_count3 !== 3'd0 || cnt_sat3 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: dout=%b/%b cnt=%0d/%0d sat=%b/%b want all 0",
                     dout8, dout3, match_count8, match_count3, cnt_sat8, cnt_sat3);
        end
    endtask

    task automatic test_default_overlap();
        logic [5:0] bits = 6'b101010;
        logic [5:0] exp  = 6'b000101;
        for (int i = 0; i < 6; i++) begin
            cycle(0, 0, 1, bits[5-i], 0);
            n_cmp++;
            if (dout8 !== exp[5-i]) begin
                n_err++;
                $display("FAIL default_overlap bit %0d: dout=%b want %b", i+1, dout8, exp[5-i]);
            end
        end
        n_cmp++;
        if (match_count8 !== 8'd2) begin
            n_err++;
            $display("FAIL default_overlap count: got %0d want 2", match_count8);
        end
    endtask

    task automatic test_non_overlap();
        logic [7:0] bits = 8'b10101010;
        logic [7:0] exp  = 8'b00010001;
        load_cfg(8'b1010, 4'd4, 1'b0);
        n_cmp++;
        if (match_count8 !== 8'd0 || dout8 !== 1'b0) begin
            n_err++;
            $display("FAIL non_overlap load: cnt=%0d dout=%b want 0 0", match_count8, dout8);
        end
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, 1, bits[7-i], 0);
            n_cmp++;
            if (dout8 !== exp[7-i]) begin
                n_err++;
                $display("FAIL non_overlap bit %0d: dout=%b want %b", i+1, dout8, exp[7-i]);
            end
        end
        n_cmp++;
        if (match_count8 !== 8'd2) begin
            n_err++;
            $display("FAIL non_overlap count: got %0d want 2", match_count8);
        end
    endtask

    task automatic test_gaps_cfg();
        logic [2:0] exp = 3'b001;
        logic [2:0] bits = 3'b110;
        load_cfg(8'b110, 4'd3, 1'b1);
        cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 0, $urandom_range(0, 1), 0);
        cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 0, $urandom_range(0, 1), 0);
        cycle(0, 1, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        n_cmp++;
        if (dout8 !== 1'b0 || match_count8 !== 8'd0) begin
            n_err++;
            $display("FAIL gaps_cfg restart: dout=%b cnt=%0d want 0 0", dout8, match_count8);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 1, bits[2-i], 0);
            if (i == 0) cycle(0, 0, 0, 0, 0);
            n_cmp++;
            if (dout8 !== exp[2-i]) begin
                n_err++;
                $display("FAIL gaps_cfg bit %0d: dout=%b want %b", i+1, dout8, exp[2-i]);
            end
        end
        n_cmp++;
        if (match_count8 !== 8'd1) begin
            n_err++;
            $display("FAIL gaps_cfg count: got %0d want 1", match_count8);
        end
    endtask

    task automatic test_len_bounds();
        logic [7:0] bits = 8'hA5;
        logic [7:0] exp  = 8'h01;
        load_cfg(8'h01, 4'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 1, 1, 0);
            n_cmp++;
            if (dout8 !== 1'b1) begin
                n_err++;
                $display("FAIL len0 bit %0d: dout=%b want 1", i+1, dout8);
            end
        end
        n_cmp++;
        if (match_count8 !== 8'd3) begin
            n_err++;
            $display("FAIL len0 count: got %0d want 3", match_count8);
        end
        load_cfg(8'hA5, 4'd15, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, 1, bits[7-i], 0);
            n_cmp++;
            if (dout8 !== exp[7-i]) begin
                n_err++;
                $display("FAIL len15 bit %0d: dout=%b want %b", i+1, dout8, exp[7-i]);
            end
        end
    endtask

    task automatic test_saturation();
        load_cfg(8'h01, 4'd1, 1'b1);
        for (int i = 0; i < 9; i++) cycle(0, 0, 1, 1, 0);
        n_cmp++;
        if (match_count3 !== 3'd7 || cnt_sat3 !== 1'b1) begin
            n_err++;
            $display("FAIL sat3: cnt=%0d sat=%b want 7 1", match_count3, cnt_sat3);
        end
        n_cmp++;
        if (match_count8 !== 8'd9 || cnt_sat8 !== 1'b0) begin
            n_err++;
            $display("FAIL sat8: cnt=%0d sat=%b want 9 0", match_count8, cnt_sat8);
        end
        cycle(0, 0, 1, 1, 1);
        n_cmp++;
        if (match_count3 !== 3'd1 || match_count8 !== 8'd1 || cnt_sat3 !== 1'b0 || dout3 !== 1'b1) begin
            n_err++;
            $display("FAIL clr_with_match: cnt=%0d/%0d sat3=%b dout3=%b want 1/1 0 1",
                     match_count8, match_count3, cnt_sat3, dout3);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp = 4'b0001;
        logic [3:0] bits = 4'b1010;
        load_cfg(8'b1010, 4'd4, 1'b1);
        cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 1, 0);
        cfg_pattern = 8'h00; cfg_len = 4'd1; cfg_overlap = 1'b1;
        cycle(1, 1, 1, 0, 1);
        n_cmp++;
        if (dout8 !== 1'b0 || match_count8 !== 8'd0 || cnt_sat8 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid outputs: dout=%b cnt=%0d sat=%b want 0 0 0",
                     dout8, match_count8, cnt_sat8);
        end
        cycle(0, 0, 1, 0, 0);
        n_cmp++;
        if (dout8 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid tail: dout=%b want 0", dout8);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 1, bits[3-i], 0);
            n_cmp++;
            if (dout8 !== exp[3-i]) begin
                n_err++;
                $display("FAIL reset_mid bit %0d: dout=%b want %b", i+1, dout8, exp[3-i]);
            end
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 199);
            if (r == 0) begin
                cycle(1, 0, 0, 0, 0);
            end else if (r < 6) begin
                cfg_pattern = 8'($urandom);
                cfg_len     = (r == 5) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4));
                cfg_overlap = 1'($urandom_range(0, 1));
                cycle(0, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3) == 0);
            end else begin
                cycle(0, 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 79) == 0);
            end
            n_cmp++;
            if (dout8 !== m_dout || dout3 !== m_dout) begin
                n_err++;
                $display("FAIL rand_dout cyc %0d: got %b/%b want %b", i, dout8, dout3, m_dout);
            end
            n_cmp++;
            if (match_count8 !== 8'(m_cnt8) || cnt_sat8 !== (m_cnt8 == 255)) begin
                n_err++;
                $display("FAIL rand_cnt8 cyc %0d: got %0d sat %b want %0d", i, match_count8, cnt_sat8, m_cnt8);
            end
            n_cmp++;
            if (match_count3 !== 3'(m_cnt3) || cnt_sat3 !== (m_cnt3 == 7)) begin
                n_err++;
                $display("FAIL rand_cnt3 cyc %0d: got %0d sat %b want %0d", i, match_count3, cnt_sat3, m_cnt3);
            end
        end
    endtask

    initial begin
        reset = 1; cfg_load = 0; din_valid = 0; din = 0; cnt_clr = 0;
        cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_overlap = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_default_overlap();
        test_non_overlap();
        test_gaps_cfg();
        test_len_bounds();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_detect_prog.md
# seq_detect_prog

Runtime-programmable serial bit-pattern detector, the parametrised successor to the fixed-pattern detector FSMs. It matches a pattern of 1 to MAX_LEN bits, loaded at run time, against a qualified serial input stream, with selectable overlapping or non-overlapping detection. Each match produces a registered one-cycle pulse and increments a saturating match counter. It sits between a serial front end and the control or status logic.

## Interface
- MAX_LEN, 8: maximum pattern length in bits; must be ≥ 2.
- LEN_W, $clog2(MAX_LEN)+1: width of the length fields.
- CNT_W, 8: width of the match counter.
- RESET_PATTERN, 'b1010: pattern active after reset, LSB-aligned.
- RESET_LEN, 4: pattern length active after reset.
- RESET_OVERLAP, 1: overlap mode active after reset.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cfg_load  in  1  latches the cfg_* fields and restarts detection.
- cfg_pattern  in  MAX_LEN  pattern, LSB-aligned; bit cfg_len-1 is the first bit received.
- cfg_len  in  LEN_W  pattern length.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- din_valid  in  1  qualifies din.
- din  in  1  serial data bit.
- cnt_clr  in  1  clears match_count.
- dout  out  1  one-cycle match pulse, registered.
- match_count  out  CNT_W  number of matches, saturating.
- cnt_sat  out  1  high while match_count is all ones.

## Operation
- **State held:**
  - active pattern, length and overlap mode (config registers);
  - hist[MAX_LEN-1:0], the history of the last accepted bits, newest in bit 0;
  - fill, a count of bits accepted since the last restart, saturating at the active length.
- **Accepted bit:** din_valid=1 and cfg_load=0. On each accepted bit:
  - hist shifts left and takes din into bit 0;
  - fill increments, saturating.
  - When din_valid=0, nothing changes. Gaps in valid are transparent to the match.
- **Match condition:** evaluated on an accepted bit, using the updated values:
  - fill_next ≥ len, and
  - hist_next[len-1:0] == pattern[len-1:0].
  - Bits above len-1 are ignored in both the history and the pattern.
- **Overlap mode 1:** history is kept after a match, so the tail of one match may start the next.
- **Overlap mode 0:** on a match, hist and fill are cleared, so the next match needs len fresh bits.
- **Length clamping:** the stored length is clamped. 0 is stored as 1; values above MAX_LEN are stored as MAX_LEN.
- **cfg_load:** has priority over din.
  - Config registers take the cfg_* values; hist and fill are cleared.
  - din is ignored that cycle and no match can occur.
  - match_count is not affected.
- **Counter:** each match increments match_count. It saturates at 2^CNT_W-1 with no wrap.
- **cnt_clr:** match_count goes to 0.
  - cnt_clr and a match in the same cycle give match_count=1: clear first, then count.
- **Reset:**
  - Config registers load the RESET_* values; hist=0, fill=0.
  - dout=0, match_count=0, cnt_sat=0.
  - Reset overrides cfg_load, cnt_clr and din.

## Timing
- dout is registered. A bit accepted at edge N that completes a match drives dout=1 for the cycle following edge N; it deasserts at edge N+1 unless another match completes.
- Back-to-back pulses are possible:
  - overlap mode with len=1;
  - any len whose pattern has a period-1 self-overlap, e.g. all ones.
- match_count updates on the same edge that raises dout. cnt_sat follows combinationally from match_count.
- A new configuration takes effect on the first accepted bit after the cfg_load edge.
- Minimum latency from the first pattern bit to dout equals len cycles when din_valid is held high.
- No back-pressure: every din_valid=1 bit is consumed.

## Test plan
- **Reset defaults (1010, overlap):** stream 1,0,1,0,1,0 with valid=1.
  - Expect dout pulses after the 4th and 6th bits; match_count=2.
- **Non-overlap:** cfg_load pattern=1010, len=4, overlap=0; stream 1,0,1,0,1,0,1,0.
  - Expect pulses after bits 4 and 8 only; match_count=2.
- **Valid gaps plus cfg_load mid-pattern:** pattern 110, len=3; send 1,1 interleaved with valid=0 cycles, then assert cfg_load with the same config, then send 0.
  - Expect no pulse. Then 1,1,0 gives 1 pulse.
- **Length boundaries:**
  - len=0 with pattern bit0=1 behaves as len=1: stream 1,1,1 gives 3 consecutive pulses.
  - len=15 clamps to 8: pattern 0xA5 matches after 8 bits.
- **Counter saturation:** with CNT_W=3, drive 9 matches.
  - Expect match_count=7 and cnt_sat=1.
  - cnt_clr together with a match gives match_count=1.
- **Reset mid-stream:** after 1,0,1, assert reset for 1 cycle, then send 0.
  - Expect no pulse and all outputs 0.
  - 1,0,1,0 then pulses once.
